status_init_ctrl: RTL

STATUS_INIT_CTRL -- requirements
Module: status_init_ctrl

---
 rtl/status_init_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/status_init_ctrl.sv
// status_init_ctrl: clears every status row after reset, then forwards upstream requests through one output register.
//
// Ports:
//   gated_clk, arst_n                 clock, asynchronous active-low reset
//   i_halt                            freezes all state while high
//   i_valid/o_ready + i_tag..i_wmask  upstream request handshake and fields
//   o_valid/i_ready + o_tag..o_wmask  registered request to the status array
//   i_flush                           re-initialise request, honoured only with STATUS_INIT_FLUSH_EN defined
//   o_init_done                       high once every row has been cleared
//
// Build option: define STATUS_INIT_FLUSH_EN to let i_flush restart the clear sweep from RUN.
module status_init_ctrl #(
    parameter int TAG_WIDTH  = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int ROW_WIDTH  = 8,
    parameter int NUM_BLOCKS = 8,
    parameter int NUM_ROWS   = 16
) (
    input  logic                  gated_clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ROW_WIDTH-1:0]  i_data,
    input  logic                  i_wen,
    input  logic [NUM_BLOCKS-1:0] i_wmask,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_flush,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic                  o_wen,
    output logic [NUM_BLOCKS-1:0] o_wmask,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_init_done
);
    typedef enum logic {INIT, RUN} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ROW_WIDTH-1:0]  data_q, data_d;
    logic                  wen_q, wen_d;
    logic [NUM_BLOCKS-1:0] wmask_q, wmask_d;
    logic                  valid_q, valid_d;
    logic                  load, flush, last_row, accept;
    // The output register advances only when it is empty or being drained.
    assign load     = ~i_halt & (~valid_q | i_ready);
    assign last_row = cnt_q == ADDR_WIDTH'(NUM_ROWS - 1);
`ifdef STATUS_INIT_FLUSH_EN
    logic flush_pend_q, flush_pend_d;
    // A flush seen while the output is stalled is remembered until the next load.
    assign flush        = (state_q == RUN) & (i_flush | flush_pend_q);
    assign flush_pend_d = i_halt ? flush_pend_q : flush & ~load;
    always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) flush_pend_q <= 1'b0;
        else flush_pend_q <= flush_pend_d;
    end
`else
    logic unused_flush;
    assign unused_flush = i_flush;
    assign flush        = 1'b0;
`endif
    always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            tag_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            wmask_q <= wmask_d;
            valid_q <= valid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load && state_q == INIT) begin
            cnt_d   = last_row ? '0 : cnt_q + 1'b1;
            state_d = last_row ? RUN : INIT;
        end else if (load && flush) begin
            state_d = INIT;
            cnt_d   = '0;
        end
    end
    always_comb begin
        o_ready = (state_q == RUN) & load & ~flush;
        accept  = i_valid & o_ready;
        tag_d   = tag_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wen_d   = wen_q;
        wmask_d = wmask_q;
        valid_d = valid_q;
        if (load && state_q == INIT) begin
            valid_d = 1'b1;
            wen_d   = 1'b1;
            wmask_d = '1;
            data_d  = '0;
            tag_d   = '0;
            addr_d  = cnt_q;
        end else if (load) begin
            valid_d = accept;
            if (accept) begin
                tag_d   = i_tag;
                addr_d  = i_addr;
                data_d  = i_data;
                wen_d   = i_wen;
                wmask_d = i_wmask;
            end
        end
    end
    assign o_tag       = tag_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_wen       = wen_q;
    assign o_wmask     = wmask_q;
    assign o_valid     = valid_q;
    assign o_init_done = state_q == RUN;
endmodule
